mem_access_unit: RTL
====================

# mem_access_unit

Pipeline-side initiator for the word-addressed data memory in the MEM stage. It takes load/store requests from the EX/MEM register, drives the data memory's address, write-data, write-enable and read-enable port, and registers extracted load data for write-back. It adds byte/halfword loads with sign or zero extension. Sub-word stores are done as a two-cycle read-modify-write, during which the pipeline is stalled. Misaligned accesses are blocked and flagged.

## Interface
- No parameters. Op encodings and FSM state encoding come from the shared package.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- req_valid  in  1  memory op present this cycle
- req_op  in  4  LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=8, SH=9, SW=10; other codes are treated as no-op
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (bits 7:0 for SB, 15:0 for SH)
- req_stall  out  1  the pipeline must hold all req_* stable while this is high
- ld_valid  out  1  registered one-cycle pulse when ld_data is valid
- ld_data  out  32  registered extended load result
- misalign  out  1  registered one-cycle pulse for a blocked misaligned access
- bad_addr  out  32  registered address of the last misaligned access
- dm_addr  out  32  byte address to the data memory (the memory uses bits 31:2)
- dm_wdata  out  32  word written to the data memory
- dm_we  out  1  write enable; the memory writes on the rising edge
- dm_re  out  1  read enable; the memory read is combinational
- dm_rdata  in  32  word read from the data memory

## Operation
- Byte lanes are little-endian: byte k sits at bits 8k+7:8k, where k = addr[1:0]. A halfword uses lane addr[1]*16.
- Alignment rule: a halfword needs addr[0]==0 and a word needs addr[1:0]==0. A misaligned op gets dm_we=dm_re=0 and no load result. misalign pulses at the next edge and bad_addr captures req_addr.
- Loads (IDLE): dm_addr=req_addr and dm_re=1. At the edge, ld_data captures the extracted lane, sign-extended for LB/LH and zero-extended for LBU/LHU. ld_valid=1 for one cycle.
- SW (IDLE): a single cycle with dm_we=1, dm_wdata=req_wdata, req_stall=0.
- SB/SH use a two-state FSM:
  - IDLE: a valid aligned SB/SH sets dm_re=1 and req_stall=1. At the edge, merge_q latches dm_rdata and addr_q latches req_addr, then the FSM goes to MERGE.
  - MERGE: dm_addr=addr_q and dm_we=1. dm_wdata is merge_q with the target lane replaced by req_wdata's low byte or halfword. req_stall=0. Next state is always IDLE.
- Outputs dm_*, req_stall are combinational from state plus request. Everything else is registered.
- When req_valid=0 or the op code is unknown: dm_we=dm_re=0 and req_stall=0.

## Timing
- Reset values: state=IDLE, ld_valid=0, ld_data=0, misalign=0, bad_addr=0, merge_q=0, addr_q=0. With state IDLE and no request, dm_we=dm_re=0 and req_stall=0.
- Latencies:
  - Load: result valid one edge after the request.
  - SW: write on the request edge.
  - SB/SH: 2 cycles, and the memory write happens on the second edge.
- Reset asserted in MERGE: state is forced to IDLE immediately, dm_we drops combinationally, and no partial write occurs.
- ld_valid and misalign are never both high.
- dm_addr passes all 32 bits through. Wrap-around at 0xFFFFFFFC is not special-cased.

## Structure
- Package mem_access_pkg holds:
  - op localparams (OP_LB … OP_SW)
  - state localparams (ST_IDLE=0, ST_MERGE=1)
  - the function is_store(op) = op[3]
- Natural sub-module: lane_extract, combinational. It maps (word, addr[1:0], op) to the extended 32-bit load value. It is instantiated once for loads; the merge path reuses the same lane select.

## Test plan
- Memory word 0x04 = 0x8899AABB:
  - LB at 0x05 -> ld_data=0xFFFFFFAA
  - LBU at 0x05 -> 0x000000AA
  - LH at 0x06 -> 0xFFFF8899
  - LW at 0x04 -> 0x8899AABB, ld_valid for one cycle each
- SB 0x5A at 0x06 over 0x8899AABB -> req_stall for 1 cycle, dm_we in the second cycle, word becomes 0x885AAABB, next LW reads it back.
- SH 0x1234 at 0x08 over 0xFFFFFFFF -> word 0xFFFF1234. SW 0xDEADBEEF at 0x0C -> single-cycle write, req_stall never high.
- LW at 0x02 and SH at 0x03 -> misalign pulses, bad_addr = 0x02 then 0x03, dm_we and dm_re stay 0, memory unchanged.
- Drop reset during the MERGE cycle of SB at 0x10 -> dm_we falls immediately, memory unchanged, and all outputs are at reset values.
- Back-to-back SB 0x11 at 0x20 then LBU at 0x20 -> ld_data=0x00000011 one edge after the load is presented.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared op codes, FSM states and alignment/lane helpers for the MEM-stage access unit.
// Pure declarations; no logic, latency or backpressure of its own.
package mem_access_pkg;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LH  = 4'd1;
  localparam logic [3:0] OP_LW  = 4'd2;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MERGE = 1'b1
  } state_t;

  function automatic logic is_store(input logic [3:0] op);
    return op[3];
  endfunction

  function automatic logic is_known_op(input logic [3:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // op[1:0] encodes access size for every known op: 0 byte, 1 half, 2 word
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'd1:    return a[0] == 1'b0;
      2'd2:    return a == 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'd0:    return {a, 3'b000};
      2'd1:    return {a[1], 4'b0000};
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/lane_extract.sv
// Selects the addressed byte/halfword lane of a memory word and sign/zero extends it.
// Combinational, zero latency; no flow control.
module lane_extract
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  op,
  output logic [31:0] data
);

  logic [31:0] shifted;

  assign shifted = word >> lane_shift(op[1:0], addr_lo);

  // op[2] set means unsigned (LBU/LHU)
  always_comb begin
    case (op[1:0])
      2'd0:    data = op[2] ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    data = op[2] ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory initiator: loads with extension, SW direct, SB/SH as read-modify-write.
// Loads 1 cycle, SB/SH 2 cycles holding the pipeline via req_stall; misaligned ops are blocked.
module mem_access_unit
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_stall,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        misalign,
  output logic [31:0] bad_addr,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_we,
  output logic        dm_re,
  input  logic [31:0] dm_rdata
);

  state_t      state_q, state_d;
  logic [31:0] merge_q, addr_q;
  logic [31:0] ld_ext, merged, lane_mask;
  logic [4:0]  merge_sh;
  logic        ld_fire, mis_fire, capture;

  lane_extract u_lane_extract (
    .word    (dm_rdata),
    .addr_lo (req_addr[1:0]),
    .op      (req_op[2:0]),
    .data    (ld_ext)
  );

  // req_op is held stable through MERGE, so its size still selects the lane
  assign merge_sh  = lane_shift(req_op[1:0], addr_q[1:0]);
  assign lane_mask = req_op[0] ? 32'h0000_FFFF : 32'h0000_00FF;
  assign merged    = (merge_q & ~(lane_mask << merge_sh)) | ((req_wdata & lane_mask) << merge_sh);

  always_comb begin
    state_d   = state_q;
    dm_addr   = req_addr;
    dm_wdata  = req_wdata;
    dm_we     = 1'b0;
    dm_re     = 1'b0;
    req_stall = 1'b0;
    ld_fire   = 1'b0;
    mis_fire  = 1'b0;
    capture   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && is_known_op(req_op)) begin
          if (!is_aligned(req_op[1:0], req_addr[1:0])) begin
            mis_fire = 1'b1;
          end else if (!is_store(req_op)) begin
            dm_re   = 1'b1;
            ld_fire = 1'b1;
          end else if (req_op == OP_SW) begin
            dm_we = 1'b1;
          end else begin
            dm_re     = 1'b1;
            req_stall = 1'b1;
            capture   = 1'b1;
            state_d   = ST_MERGE;
          end
        end
      end
      ST_MERGE: begin
        dm_addr  = addr_q;
        dm_wdata = merged;
        dm_we    = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Keep the memory port quiet while reset is held, even mid-merge
    if (!reset) begin
      dm_we     = 1'b0;
      dm_re     = 1'b0;
      req_stall = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ld_valid <= 1'b0;
      ld_data  <= 32'd0;
      misalign <= 1'b0;
      bad_addr <= 32'd0;
      merge_q  <= 32'd0;
      addr_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      ld_valid <= ld_fire;
      misalign <= mis_fire;
      if (ld_fire)  ld_data  <= ld_ext;
      if (mis_fire) bad_addr <= req_addr;
      if (capture) begin
        merge_q <= dm_rdata;
        addr_q  <= req_addr;
      end
    end
  end

endmodule
